// File: rtl/aq_djpeg_pixout_if.sv
`default_nettype none
// ============================================================================
// Module      : aq_djpeg_pixout_if
// Description : Pixel bus between the JPEG decoder core, the pixel output
//               FIFO and the downstream pixel sink. The slave modport is the
//               FIFO side; the master modport is the decoder/sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface aq_djpeg_pixout_if #(
   parameter int DEPTH = 16
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   // Decoder side
   logic              in_idle;
   logic              in_enable;
   logic [15:0]       in_width;
   logic [15:0]       in_height;
   logic [15:0]       in_x;
   logic [15:0]       in_y;
   logic [7:0]        in_r;
   logic [7:0]        in_g;
   logic [7:0]        in_b;
   logic              in_full;

   // Sink side
   logic              out_valid;
   logic              out_ready;
   logic [23:0]       out_data;
   logic [15:0]       out_x;
   logic [15:0]       out_y;
   logic              out_sof;
   logic              out_eol;

   // Status
   logic              overflow;
   logic [LVL_W-1:0]  level;

   modport slave (
      input  in_idle, in_enable, in_width, in_height, in_x, in_y,
             in_r, in_g, in_b, out_ready,
      output in_full, out_valid, out_data, out_x, out_y, out_sof, out_eol,
             overflow, level
   );

   modport master (
      output in_idle, in_enable, in_width, in_height, in_x, in_y,
             in_r, in_g, in_b, out_ready,
      input  in_full, out_valid, out_data, out_x, out_y, out_sof, out_eol,
             overflow, level
   );
endinterface
`default_nettype wire

// File: rtl/aq_djpeg_pixout.sv
`default_nettype none
// ============================================================================
// Module      : aq_djpeg_pixout
// Description : Pixel output stage of the JPEG decoder. Formats each decoded
//               pixel (RGB888 / RGB565 / Gray8), tags it with coordinate,
//               start-of-frame and end-of-line, and buffers it in a
//               first-word-fall-through FIFO with almost-full back-pressure
//               to the decoder and a sticky overflow flag.
//               Optional macro AQ_DJPEG_PIXOUT_CROP_EN drops MCU padding
//               pixels that lie outside the image.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_djpeg_pixout #(
   parameter int DEPTH        = 16,
   parameter int AFULL_MARGIN = 4,
   parameter int PIX_FMT      = 0
) (
   input  logic              clk,
   input  logic              rst,
   aq_djpeg_pixout_if.slave  bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = 24 + 16 + 16 + 2;

   localparam logic [LVL_W-1:0] C_DEPTH_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] C_AFULL_TH  = LVL_W'(DEPTH - AFULL_MARGIN);

   // ------------------------------------------------------------------------
   // Pixel formatting
   // ------------------------------------------------------------------------
   logic [23:0] w_fmt_data;

   generate
      if (PIX_FMT == 1) begin : g_fmt_rgb565
         assign w_fmt_data = {8'h00, bus.in_r[7:3], bus.in_g[7:2], bus.in_b[7:3]};
      end else if (PIX_FMT == 2) begin : g_fmt_gray8
         // Weights sum to 256, so the 16-bit sum never wraps.
         logic [15:0] w_luma_sum;
         assign w_luma_sum = (16'd77  * {8'h00, bus.in_r})
                           + (16'd150 * {8'h00, bus.in_g})
                           + (16'd29  * {8'h00, bus.in_b});
         assign w_fmt_data = {16'h0000, w_luma_sum[15:8]};
      end else begin : g_fmt_rgb888
         assign w_fmt_data = {bus.in_r, bus.in_g, bus.in_b};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Frame-window test for MCU padding
   // ------------------------------------------------------------------------
   logic w_in_frame;

`ifdef AQ_DJPEG_PIXOUT_CROP_EN
   assign w_in_frame = (bus.in_x < bus.in_width) && (bus.in_y < bus.in_height);
`else
   logic w_unused_height;
   assign w_in_frame      = 1'b1;
   assign w_unused_height = ^bus.in_height;
`endif

   // ------------------------------------------------------------------------
   // Entry tagging: {data, x, y, sof, eol}
   // ------------------------------------------------------------------------
   logic [15:0]        w_width_m1;
   logic               w_sof;
   logic               w_eol;
   logic [ENTRY_W-1:0] w_entry;

   assign w_width_m1 = bus.in_width - 16'd1;
   assign w_sof      = (bus.in_x == 16'd0) && (bus.in_y == 16'd0);
   assign w_eol      = (bus.in_x == w_width_m1);
   assign w_entry    = {w_fmt_data, bus.in_x, bus.in_y, w_sof, w_eol};

   // ------------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wptr_q;
   logic [PTR_W-1:0]   rptr_q;
   logic [LVL_W-1:0]   level_q;
   logic [LVL_W-1:0]   level_d;
   logic               full_q;
   logic               ovf_q;

   logic               w_valid;
   logic               w_pop;
   logic               w_push_req;
   logic               w_push_ok;
   logic               w_drop;

   assign w_valid    = (level_q != '0);
   assign w_pop      = w_valid && bus.out_ready;
   assign w_push_req = bus.in_enable && w_in_frame;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_push_ok  = w_push_req && ((level_q != C_DEPTH_LVL) || w_pop);
   assign w_drop     = w_push_req && (level_q == C_DEPTH_LVL) && !w_pop;

   // Next occupancy; a flush overrides any push or pop.
   always_comb begin
      level_d = level_q;
      if (bus.in_idle) begin
         level_d = '0;
      end else if (w_push_ok && !w_pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (!w_push_ok && w_pop) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   // Pointers, occupancy, almost-full and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.in_idle) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= (level_d >= C_AFULL_TH);
         ovf_q   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         level_q <= level_d;
         full_q  <= (level_d >= C_AFULL_TH);
         if (w_drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Storage array; contents need no reset because level gates visibility.
   always_ff @(posedge clk) begin
      if (rst && !bus.in_idle && w_push_ok) begin
         mem_q[wptr_q] <= w_entry;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: head of FIFO, forced to zero while nothing is valid
   // ------------------------------------------------------------------------
   logic [ENTRY_W-1:0] w_head;

   assign w_head        = mem_q[rptr_q];
   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_valid ? w_head[57:34] : 24'h000000;
   assign bus.out_x     = w_valid ? w_head[33:18] : 16'h0000;
   assign bus.out_y     = w_valid ? w_head[17:2]  : 16'h0000;
   assign bus.out_sof   = w_valid & w_head[1];
   assign bus.out_eol   = w_valid & w_head[0];
   assign bus.in_full   = full_q;
   assign bus.overflow  = ovf_q;
   assign bus.level     = level_q;

endmodule
`default_nettype wire
